// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Instruction fetch queue between fetch and decode. It is a
//               circular buffer of {pc, instr} entries kept in program order,
//               with a valid/ready handshake toward decode. Its ready output
//               doubles as the fetch stall signal. A flush discards every
//               buffered entry.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int N     = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enq_valid_F,
    input  logic [N-1:0]                 enq_pc_F,
    input  logic [31:0]                  enq_instr_F,
    output logic                         enq_ready_F,
    input  logic                         flush_F,
    output logic                         deq_valid_D,
    output logic [N-1:0]                 deq_pc_D,
    output logic [31:0]                  deq_instr_D,
    input  logic                         deq_ready_D,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_CNT_W   = $clog2(DEPTH + 1);
    localparam int c_ENTRY_W = N + 32;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    logic [c_ENTRY_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;

    logic                 w_enq_ready;
    logic                 w_deq_valid;
    logic                 w_enq_fire;
    logic                 w_deq_fire;
    logic [c_ENTRY_W-1:0] w_head;

    // Handshake status depends only on the registered occupancy, so there is
    // no combinational path from decode's ready back to fetch.
    assign w_enq_ready = (r_count != c_FULL);
    assign w_deq_valid = (r_count != '0);
    assign w_enq_fire  = enq_valid_F & w_enq_ready;
    assign w_deq_fire  = w_deq_valid & deq_ready_D;
    assign w_head      = r_mem[r_rd_ptr];

    assign enq_ready_F = w_enq_ready;
    assign deq_valid_D = w_deq_valid;
    assign count       = r_count;

    // Gate the head entry so stale storage never leaks out while empty.
    always_comb begin
        deq_pc_D    = '0;
        deq_instr_D = '0;
        if (w_deq_valid) begin
            deq_pc_D    = w_head[c_ENTRY_W-1:32];
            deq_instr_D = w_head[31:0];
        end
    end

    // Entry storage: written on enqueue, never cleared (output gating hides
    // stale contents). A flush cycle's enqueue is dropped by the pointer reset
    // below, so the write itself need not be suppressed.
    always_ff @(posedge clk) begin
        if (w_enq_fire) begin
            r_mem[r_wr_ptr] <= {enq_pc_F, enq_instr_F};
        end
    end

    // Pointer and occupancy bookkeeping; flush overrides any same-cycle
    // enqueue or dequeue. Pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_F) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq_fire) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_deq_fire) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_enq_fire && !w_deq_fire) begin
                r_count <= r_count + 1'b1;
            end else if (w_deq_fire && !w_enq_fire) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue against a queue-based
//               reference model of the expected program-order behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int N     = 64;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int OW    = 2 + CW + N + 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enq_valid_F = 1'b0;
    logic [N-1:0]  enq_pc_F = '0;
    logic [31:0]   enq_instr_F = '0;
    logic          enq_ready_F;
    logic          flush_F = 1'b0;
    logic          deq_valid_D;
    logic [N-1:0]  deq_pc_D;
    logic [31:0]   deq_instr_D;
    logic          deq_ready_D = 1'b0;
    logic [CW-1:0] count;

    fetch_queue #(.N(N), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .enq_valid_F (enq_valid_F),
        .enq_pc_F    (enq_pc_F),
        .enq_instr_F (enq_instr_F),
        .enq_ready_F (enq_ready_F),
        .flush_F     (flush_F),
        .deq_valid_D (deq_valid_D),
        .deq_pc_D    (deq_pc_D),
        .deq_instr_D (deq_instr_D),
        .deq_ready_D (deq_ready_D),
        .count       (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] pc;
        logic [31:0]  instr;
    } ent_t;

    ent_t mq[$];
    int   vectors = 0;
    int   miscompares = 0;

    logic [OW-1:0] dut_out;
    assign dut_out = {enq_ready_F, deq_valid_D, count, deq_pc_D, deq_instr_D};

    // Expected visible outputs from the model's contents.
    function automatic logic [OW-1:0] model_out();
        logic [CW-1:0] c;
        c = CW'(mq.size());
        if (mq.size() == 0)
            return {1'b1, 1'b0, c, {N{1'b0}}, 32'h0};
        return {(mq.size() != DEPTH), 1'b1, c, mq[0].pc, mq[0].instr};
    endfunction

    // Drive one cycle of stimulus, update the model at the edge, return at
    // the following falling edge with inputs idled.
    task automatic cycle(input logic ev, input logic [N-1:0] pc,
                         input logic [31:0] ins, input logic dr, input logic fl);
        ent_t e;
        bit   d, q;
        enq_valid_F = ev; enq_pc_F = pc; enq_instr_F = ins;
        deq_ready_D = dr; flush_F = fl;
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            d = (mq.size() != 0) && dr;
            q = ev && (mq.size() != DEPTH);
            if (d) void'(mq.pop_front());
            if (q) begin
                e.pc = pc; e.instr = ins;
                mq.push_back(e);
            end
        end
        @(negedge clk);
        enq_valid_F = 1'b0; deq_ready_D = 1'b0; flush_F = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if (dut_out !== model_out()) begin
            miscompares++;
            $display("FAIL reset_held: got %h expected %h", dut_out, model_out());
        end
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b0);
            vectors++;
            if (dut_out !== {1'b1, 1'b0, {CW{1'b0}}, {N{1'b0}}, 32'h0}) begin
                miscompares++;
                $display("FAIL reset_idle[%0d]: got %h expected idle", i, dut_out);
            end
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, N'(4 * i), 32'h8B020020 + 32'(i), 1'b0, 1'b0);
            vectors++;
            if (dut_out !== model_out()) begin
                miscompares++;
                $display("FAIL fill[%0d]: got %h expected %h", i, dut_out, model_out());
            end
        end
        vectors++;
        if (count !== CW'(4) || enq_ready_F !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_full: got count=%0d ready=%b expected 4/0", count, enq_ready_F);
        end
        cycle(1'b1, N'(32'h10), 32'hDEAD0010, 1'b0, 1'b0);
        vectors++;
        if (count !== CW'(4) || deq_pc_D !== '0) begin
            miscompares++;
            $display("FAIL fill_refuse: got count=%0d head=%h expected 4/0", count, deq_pc_D);
        end
    endtask

    task automatic test_full_simul();
        cycle(1'b1, N'(32'h10), 32'hDEAD0010, 1'b1, 1'b0);
        vectors++;
        if (dut_out !== model_out() || count !== CW'(3) || deq_pc_D !== N'(4)) begin
            miscompares++;
            $display("FAIL full_simul: got %h expected %h", dut_out, model_out());
        end
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        cycle(1'b1, N'(32'h14), 32'h8B020099, 1'b1, 1'b0);
        vectors++;
        if (dut_out !== model_out() || count !== CW'(2) || deq_pc_D !== N'(32'hC)) begin
            miscompares++;
            $display("FAIL both_at_2: got %h expected %h", dut_out, model_out());
        end
    endtask

    task automatic test_wrap();
        logic [N-1:0] got[$];
        int           sent;
        bit           dr, ev, acc;
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        sent = 0;
        for (int c = 0; c < 60 && got.size() < 10; c++) begin
            dr = (c % 2 == 0);
            if (deq_valid_D && dr) begin
                got.push_back(deq_pc_D);
                vectors++;
                if (deq_pc_D !== N'(4 * (got.size() - 1)) ||
                    deq_instr_D !== 32'h8B020020 + 32'(got.size() - 1)) begin
                    miscompares++;
                    $display("FAIL wrap_order[%0d]: got pc=%h instr=%h", got.size() - 1,
                             deq_pc_D, deq_instr_D);
                end
            end
            ev  = (sent < 10);
            acc = ev && (mq.size() != DEPTH);
            cycle(ev, N'(4 * sent), 32'h8B020020 + 32'(sent), dr, 1'b0);
            if (acc) sent++;
            vectors++;
            if (dut_out !== model_out()) begin
                miscompares++;
                $display("FAIL wrap_cycle[%0d]: got %h expected %h", c, dut_out, model_out());
            end
        end
        vectors++;
        if (got.size() != 10) begin
            miscompares++;
            $display("FAIL wrap_count: got %0d entries expected 10", got.size());
        end
    endtask

    task automatic test_flush();
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            cycle(1'b1, N'(32'h80 + 4 * i), 32'h11110000 + 32'(i), 1'b0, 1'b0);
        vectors++;
        if (count !== CW'(3)) begin
            miscompares++;
            $display("FAIL flush_setup: got count=%0d expected 3", count);
        end
        cycle(1'b1, N'(32'h100), 32'h22220100, 1'b1, 1'b1);
        vectors++;
        if (count !== '0 || deq_valid_D !== 1'b0 || enq_ready_F !== 1'b1 ||
            dut_out !== model_out()) begin
            miscompares++;
            $display("FAIL flush_empty: got %h expected %h", dut_out, model_out());
        end
        cycle(1'b1, N'(32'h200), 32'h22220200, 1'b0, 1'b0);
        vectors++;
        if (deq_pc_D !== N'(32'h200) || deq_instr_D !== 32'h22220200 ||
            dut_out !== model_out()) begin
            miscompares++;
            $display("FAIL flush_next_head: got pc=%h expected 200", deq_pc_D);
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        cycle(1'b1, N'(32'h30), 32'h33330030, 1'b0, 1'b0);
        cycle(1'b1, N'(32'h34), 32'h33330034, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (count !== '0 || deq_valid_D !== 1'b0 || enq_ready_F !== 1'b1 ||
            deq_pc_D !== '0 || deq_instr_D !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got %h expected empty", dut_out);
        end
        mq.delete();
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b1, N'(32'h40), 32'h44440040, 1'b0, 1'b0);
        vectors++;
        if (deq_pc_D !== N'(32'h40) || deq_valid_D !== 1'b1 || dut_out !== model_out()) begin
            miscompares++;
            $display("FAIL async_reset_enq: got %h expected %h", dut_out, model_out());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 4) != 0, {$urandom, $urandom}, $urandom,
                  ($urandom % 3) != 0, ($urandom % 25) == 0);
            vectors++;
            if (dut_out !== model_out()) begin
                miscompares++;
                $display("FAIL random[%0d]: got %h expected %h", i, dut_out, model_out());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_simul();
        test_wrap();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the fetch stage and decode. Each cycle it accepts one fetched instruction word together with its PC. It holds up to DEPTH entries in program order and presents the oldest entry to decode through a valid/ready handshake. When fetch redirects on a taken branch (PCSrc), the queue discards every buffered entry. Its ready output is the stall signal that fetch uses to hold its PC.

## Interface
- N, 64: PC width in bits.
- DEPTH, 4: number of entries; a power of two, ≥ 2.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- enq_valid_F  in  1  fetch presents a valid instruction this cycle.
- enq_pc_F  in  N  PC of the presented instruction (imem address).
- enq_instr_F  in  32  instruction word read from instruction memory.
- enq_ready_F  out  1  queue can accept an entry this cycle; low = fetch must stall.
- flush_F  in  1  taken branch / redirect; discard all entries.
- deq_valid_D  out  1  head entry is valid.
- deq_pc_D  out  N  PC of the head entry.
- deq_instr_D  out  32  instruction word of the head entry.
- deq_ready_D  in  1  decode consumes the head entry this cycle.
- count  out  $clog2(DEPTH+1)  number of occupied entries.

## Operation
- Circular buffer of DEPTH entries; each entry holds {pc, instr}.
- Write pointer (wr_ptr), read pointer (rd_ptr) and count are registers. Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- enq_ready_F = (count != DEPTH), derived only from registered state. There is no combinational path from deq_ready_D.
- deq_valid_D = (count != 0).
- deq_pc_D and deq_instr_D are read from mem[rd_ptr] when deq_valid_D = 1. When deq_valid_D = 0 both are forced to 0.
- Enqueue fires when enq_valid_F & enq_ready_F: mem[wr_ptr] ← {enq_pc_F, enq_instr_F}, then wr_ptr+1.
- Dequeue fires when deq_valid_D & deq_ready_D: rd_ptr+1.
- count next state:
  - +1 on enqueue only.
  - −1 on dequeue only.
  - unchanged when both fire or neither fires.
- Full with deq_ready_D = 1: the dequeue happens and the enqueue is refused, because enq_ready_F = 0. The queue reads DEPTH−1 in the next cycle.
- Empty with enq_valid_F = 1: the entry is written. There is no bypass, so deq_valid_D rises in the next cycle.
- flush_F = 1 is synchronous and has highest priority:
  - next cycle: wr_ptr = rd_ptr = count = 0.
  - any enqueue or dequeue in the flush cycle is discarded. The dequeue handshake still appears on the outputs that cycle; decode must also squash on flush_F.
- Entry contents are never cleared. The output gating makes stale data invisible.
- Ignored inputs:
  - enq_valid_F = 0: enq_pc_F and enq_instr_F are ignored.
  - deq_valid_D = 0: deq_ready_D is ignored.

## Timing
- Asynchronous reset (reset = 0), effective immediately and independent of clk:
  - wr_ptr = rd_ptr = count = 0.
  - enq_ready_F = 1, deq_valid_D = 0, deq_pc_D = 0, deq_instr_D = 0.
- Reset asserted mid-operation drops all entries immediately. After release, the first enqueue is accepted on the first rising edge.
- Latency enqueue → head: 1 cycle when the queue is empty. Otherwise the entry reaches the head after all older entries have been dequeued.
- Throughput: one enqueue and one dequeue per cycle, sustained, for any count from 1 to DEPTH−1.
- Flush → empty: the outputs show deq_valid_D = 0 and enq_ready_F = 1 on the cycle after the flush edge.
- All state updates happen on the rising edge of clk. Outputs are functions of registered state only.

## Test plan
- Reset/idle: hold reset = 0, then release with no enqueues → enq_ready_F = 1, deq_valid_D = 0, count = 0, deq_instr_D = 0 across 5 cycles.
- Fill to full: deq_ready_D = 0; enqueue PCs 0x0, 0x4, 0x8, 0xC (instr 0x8B020020+i) → count = 4 and enq_ready_F = 0. A fifth enq_valid_F is refused, and count stays at 4.
- Full with simultaneous ops: at count = 4, assert deq_ready_D = 1 and enq_valid_F = 1 (PC 0x10) → PC 0x0 is consumed, 0x10 is not accepted, and count = 3. At count = 2, simultaneous enq and deq → count stays at 2 and the head advances in order.
- Wrap-around: stream 10 sequential PCs (0x0 to 0x24) with deq_ready_D toggling 1,0,1,… → decode receives all 10 in order with matching instr, none lost or duplicated, and the pointers wrap twice.
- Flush priority: at count = 3, assert flush_F together with enq_valid_F (PC 0x100) and deq_ready_D = 1 → next cycle count = 0 and deq_valid_D = 0. The following enqueue, PC 0x200, is the next head.
- Asynchronous reset mid-stream: at count = 2, drive reset = 0 between clock edges → count = 0 and deq_valid_D = 0 before the next edge. After release, enqueue PC 0x40, which appears at the head one cycle later.
